// File: rtl/rpn_ascii_tokenizer.sv
// ASCII expression tokenizer: turns a byte stream into number/operator tokens on a stb/ack port.
// Optional build macro TOKENIZER_SATURATE_EN: saturate the number accumulator and flag ovf instead of wrapping.
module rpn_ascii_tokenizer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [7:0]  SEP_CHAR   = 8'h20,
  parameter logic [7:0]  EOL_CHAR   = 8'h0A
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_stb,
  input  logic [7:0]            in_data,
  output logic                  in_ack,
  output logic                  out_stb,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  is_out_op,
  input  logic                  out_ack,
  output logic                  bad_char,
  output logic                  ovf
);

  typedef enum logic [1:0] {
    ACCEPT   = 2'd0,
    EMIT_NUM = 2'd1,
    EMIT_OP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  have_num_q, have_num_d;
  logic [7:0]            pend_op_q, pend_op_d;
  logic                  in_ack_q, in_ack_d;
  logic                  out_stb_q, out_stb_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  is_out_op_q, is_out_op_d;
  logic                  bad_char_q, bad_char_d;

  logic                  is_digit;
  logic                  is_op;
  logic [7:0]            digit;
  logic [DATA_WIDTH-1:0] acc_next;

  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_op    = (in_data == 8'h2B) || (in_data == 8'h2D) || (in_data == 8'h2A) ||
                    (in_data == 8'h2F) || (in_data == 8'h28) || (in_data == 8'h29) ||
                    (in_data == EOL_CHAR);
  assign digit    = in_data - 8'h30;

`ifdef TOKENIZER_SATURATE_EN
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH+3:0] prod_ext;
  logic                  sat;

  // Four guard bits are enough to hold acc*10+9 without loss.
  assign prod_ext = {4'b0000, acc_q} * (DATA_WIDTH+4)'(10) + (DATA_WIDTH+4)'(digit);
  assign sat      = |prod_ext[DATA_WIDTH+3:DATA_WIDTH];
  assign acc_next = sat ? {DATA_WIDTH{1'b1}} : prod_ext[DATA_WIDTH-1:0];
  assign ovf      = ovf_q;
`else
  assign acc_next = acc_q * DATA_WIDTH'(10) + DATA_WIDTH'(digit);
  assign ovf      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    have_num_d  = have_num_q;
    pend_op_d   = pend_op_q;
    out_data_d  = out_data_q;
    is_out_op_d = is_out_op_q;
    bad_char_d  = 1'b0;
`ifdef TOKENIZER_SATURATE_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      ACCEPT: begin
        if (in_stb && in_ack_q) begin
          if (is_digit) begin
            acc_d      = acc_next;
            have_num_d = 1'b1;
`ifdef TOKENIZER_SATURATE_EN
            if (sat) ovf_d = 1'b1;
`endif
          end else if (is_op) begin
            pend_op_d = in_data;
            if (have_num_q) begin
              state_d     = EMIT_NUM;
              out_data_d  = acc_q;
              is_out_op_d = 1'b0;
            end else begin
              state_d     = EMIT_OP;
              out_data_d  = DATA_WIDTH'(in_data);
              is_out_op_d = 1'b1;
            end
          end else if (in_data == SEP_CHAR) begin
            if (have_num_q) begin
              state_d     = EMIT_NUM;
              out_data_d  = acc_q;
              is_out_op_d = 1'b0;
            end
          end else begin
            bad_char_d = 1'b1;
          end
        end
      end
      EMIT_NUM: begin
        if (out_ack) begin
          acc_d      = '0;
          have_num_d = 1'b0;
`ifdef TOKENIZER_SATURATE_EN
          ovf_d      = 1'b0;
`endif
          // A zero pend_op means the number was closed by a separator only.
          if (pend_op_q != 8'h00) begin
            state_d     = EMIT_OP;
            out_data_d  = DATA_WIDTH'(pend_op_q);
            is_out_op_d = 1'b1;
          end else begin
            state_d = ACCEPT;
          end
        end
      end
      EMIT_OP: begin
        if (out_ack) begin
          pend_op_d = 8'h00;
          state_d   = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
    in_ack_d  = (state_d == ACCEPT);
    out_stb_d = (state_d != ACCEPT);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ACCEPT;
      acc_q       <= '0;
      have_num_q  <= 1'b0;
      pend_op_q   <= 8'h00;
      in_ack_q    <= 1'b0;
      out_stb_q   <= 1'b0;
      out_data_q  <= '0;
      is_out_op_q <= 1'b0;
      bad_char_q  <= 1'b0;
`ifdef TOKENIZER_SATURATE_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      have_num_q  <= have_num_d;
      pend_op_q   <= pend_op_d;
      in_ack_q    <= in_ack_d;
      out_stb_q   <= out_stb_d;
      out_data_q  <= out_data_d;
      is_out_op_q <= is_out_op_d;
      bad_char_q  <= bad_char_d;
`ifdef TOKENIZER_SATURATE_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ack    = in_ack_q;
  assign out_stb   = out_stb_q;
  assign out_data  = out_data_q;
  assign is_out_op = is_out_op_q;
  assign bad_char  = bad_char_q;

endmodule

// File: tb/tb_rpn_ascii_tokenizer.sv
// Directed bench for rpn_ascii_tokenizer; follows TOKENIZER_SATURATE_EN like the RTL.
module tb_rpn_ascii_tokenizer;

  logic        CLK;
  logic        RST;
  logic        in_stb;
  logic [7:0]  in_data;
  logic        in_ack;
  logic        out_stb;
  logic [31:0] out_data;
  logic        is_out_op;
  logic        out_ack;
  logic        bad_char;
  logic        ovf;

  typedef struct packed {
    logic [31:0] d;
    logic        op;
    logic        ov;
  } tok_t;

  tok_t tq[$];
  int   nvec = 0;
  int   nerr = 0;
  int   ack_viol = 0;
  int   bad_cnt = 0;
  bit   snd_done;

  rpn_ascii_tokenizer #(.DATA_WIDTH(32), .SEP_CHAR(8'h20), .EOL_CHAR(8'h0A)) dut (
    .CLK(CLK), .RST(RST), .in_stb(in_stb), .in_data(in_data), .in_ack(in_ack),
    .out_stb(out_stb), .out_data(out_data), .is_out_op(is_out_op), .out_ack(out_ack),
    .bad_char(bad_char), .ovf(ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Outputs only move on rising edges, so the falling edge sees the values the next edge will act on.
  always @(negedge CLK) begin
    if (!RST) begin
      if (out_stb && out_ack) tq.push_back('{d: out_data, op: is_out_op, ov: ovf});
      if (out_stb && in_ack) ack_viol++;
      if (bad_char) bad_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge CLK);
    in_stb  = 1'b1;
    in_data = b;
    while (!in_ack && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ack) begin
      $display("FAIL send_timeout: byte %h not accepted, in_ack=%b required 1", b, in_ack);
      nerr++;
      in_stb = 1'b0;
    end else begin
      @(posedge CLK);
      #1;
      in_stb = 1'b0;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_tokens(input int n, output bit ok);
    int c;
    c = 0;
    while (tq.size() < n && c < 300) begin
      @(posedge CLK);
      #1;
      c++;
    end
    ok = (tq.size() >= n);
  endtask

  task automatic test_reset();
    RST = 1'b1; in_stb = 1'b0; in_data = 8'h00; out_ack = 1'b0;
    repeat (3) @(negedge CLK);
    nvec++; if (in_ack !== 1'b0) begin $display("FAIL rst_in_ack: got %b want 0", in_ack); nerr++; end
    nvec++; if (out_stb !== 1'b0) begin $display("FAIL rst_out_stb: got %b want 0", out_stb); nerr++; end
    nvec++; if (out_data !== 32'h0) begin $display("FAIL rst_out_data: got %h want 0", out_data); nerr++; end
    nvec++; if (is_out_op !== 1'b0) begin $display("FAIL rst_is_out_op: got %b want 0", is_out_op); nerr++; end
    nvec++; if (bad_char !== 1'b0) begin $display("FAIL rst_bad_char: got %b want 0", bad_char); nerr++; end
    nvec++; if (ovf !== 1'b0) begin $display("FAIL rst_ovf: got %b want 0", ovf); nerr++; end
    RST = 1'b0;
    #1;
    nvec++; if (in_ack !== 1'b0) begin $display("FAIL rst_release_in_ack: got %b want 0", in_ack); nerr++; end
    @(posedge CLK); #1;
    nvec++; if (in_ack !== 1'b1) begin $display("FAIL rst_first_edge_in_ack: got %b want 1", in_ack); nerr++; end
  endtask

  task automatic test_basic();
    logic [31:0] ed [4] = '{32'd12, 32'h2B, 32'd3, 32'h0A};
    logic        eo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit ok;
    int v0;
    tq.delete(); out_ack = 1'b1; v0 = ack_viol;
    send_str("12+3\n");
    wait_tokens(4, ok);
    repeat (5) @(posedge CLK); #1;
    nvec++; if (!ok || tq.size() !== 4) begin $display("FAIL basic_count: got %0d tokens want 4", tq.size()); nerr++; end
    for (int i = 0; i < 4 && i < tq.size(); i++) begin
      nvec++;
      if (tq[i].d !== ed[i] || tq[i].op !== eo[i]) begin
        $display("FAIL basic_tok%0d: got (%h,%b) want (%h,%b)", i, tq[i].d, tq[i].op, ed[i], eo[i]); nerr++;
      end
    end
    nvec++; if (ack_viol !== v0) begin $display("FAIL basic_in_ack_during_emit: got %0d want %0d", ack_viol, v0); nerr++; end
  endtask

  task automatic test_backpressure();
    logic [31:0] ed [4] = '{32'd7, 32'd8, 32'h2A, 32'h0A};
    logic        eo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bit ok;
    int n, unstable;
    tq.delete(); out_ack = 1'b0; snd_done = 1'b0;
    fork
      begin send_str("7 8*\n"); snd_done = 1'b1; end
    join_none
    n = 0;
    while (!out_stb && n < 100) begin @(negedge CLK); n++; end
    nvec++; if (out_stb !== 1'b1) begin $display("FAIL bp_first_token: out_stb got %b want 1", out_stb); nerr++; end
    unstable = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_stb !== 1'b1 || out_data !== 32'd7 || is_out_op !== 1'b0 || in_ack !== 1'b0) unstable++;
      @(negedge CLK);
    end
    nvec++; if (unstable !== 0) begin $display("FAIL bp_hold: %0d unstable cycles want 0", unstable); nerr++; end
    @(posedge CLK); #1;
    out_ack = 1'b1;
    wait_tokens(4, ok);
    n = 0;
    while (!snd_done && n < 100) begin @(posedge CLK); n++; end
    repeat (5) @(posedge CLK); #1;
    nvec++; if (!ok || tq.size() !== 4) begin $display("FAIL bp_count: got %0d tokens want 4", tq.size()); nerr++; end
    for (int i = 0; i < 4 && i < tq.size(); i++) begin
      nvec++;
      if (tq[i].d !== ed[i] || tq[i].op !== eo[i]) begin
        $display("FAIL bp_tok%0d: got (%h,%b) want (%h,%b)", i, tq[i].d, tq[i].op, ed[i], eo[i]); nerr++;
      end
    end
  endtask

  task automatic test_bad_char();
    logic [31:0] ed [4] = '{32'h28, 32'd1, 32'h29, 32'h0A};
    logic        eo [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit ok;
    int b0;
    tq.delete(); out_ack = 1'b1; b0 = bad_cnt;
    send_str("(1)x\n");
    wait_tokens(4, ok);
    repeat (5) @(posedge CLK); #1;
    nvec++; if (!ok || tq.size() !== 4) begin $display("FAIL bad_count_tokens: got %0d want 4", tq.size()); nerr++; end
    for (int i = 0; i < 4 && i < tq.size(); i++) begin
      nvec++;
      if (tq[i].d !== ed[i] || tq[i].op !== eo[i]) begin
        $display("FAIL bad_tok%0d: got (%h,%b) want (%h,%b)", i, tq[i].d, tq[i].op, ed[i], eo[i]); nerr++;
      end
    end
    nvec++; if (bad_cnt - b0 !== 1) begin $display("FAIL bad_char_pulses: got %0d want 1", bad_cnt - b0); nerr++; end
  endtask

  task automatic test_overflow();
    bit ok;
`ifdef TOKENIZER_SATURATE_EN
    logic [31:0] ed = 32'hFFFF_FFFF;
    logic        eov = 1'b1;
`else
    logic [31:0] ed = 32'h0;
    logic        eov = 1'b0;
`endif
    tq.delete(); out_ack = 1'b1;
    send_str("4294967296 ");
    wait_tokens(1, ok);
    @(negedge CLK);
    nvec++; if (ovf !== 1'b0) begin $display("FAIL ovf_after_ack: got %b want 0", ovf); nerr++; end
    repeat (5) @(posedge CLK); #1;
    nvec++; if (!ok || tq.size() !== 1) begin $display("FAIL ovf_count: got %0d tokens want 1", tq.size()); nerr++; end
    if (tq.size() > 0) begin
      nvec++;
      if (tq[0].d !== ed || tq[0].op !== 1'b0) begin
        $display("FAIL ovf_tok: got (%h,%b) want (%h,0)", tq[0].d, tq[0].op, ed); nerr++;
      end
      nvec++;
      if (tq[0].ov !== eov) begin $display("FAIL ovf_flag: got %b want %b", tq[0].ov, eov); nerr++; end
    end
  endtask

  task automatic test_rst_abort();
    logic [31:0] ed [2] = '{32'd5, 32'h0A};
    logic        eo [2] = '{1'b0, 1'b1};
    bit ok;
    int n;
    tq.delete(); out_ack = 1'b0; snd_done = 1'b0;
    fork
      begin send_str("99+"); snd_done = 1'b1; end
    join_none
    n = 0;
    while ((!out_stb || !snd_done) && n < 100) begin @(negedge CLK); n++; end
    nvec++;
    if (out_stb !== 1'b1 || out_data !== 32'd99) begin
      $display("FAIL abort_pending: got (%b,%h) want (1,00000063)", out_stb, out_data); nerr++;
    end
    @(posedge CLK); #2;
    RST = 1'b1;
    #1;
    nvec++; if (out_stb !== 1'b0) begin $display("FAIL abort_out_stb: got %b want 0", out_stb); nerr++; end
    nvec++; if (in_ack !== 1'b0) begin $display("FAIL abort_in_ack: got %b want 0", in_ack); nerr++; end
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    out_ack = 1'b1;
    tq.delete();
    send_str("5\n");
    wait_tokens(2, ok);
    repeat (6) @(posedge CLK); #1;
    nvec++; if (!ok || tq.size() !== 2) begin $display("FAIL abort_count: got %0d tokens want 2", tq.size()); nerr++; end
    for (int i = 0; i < 2 && i < tq.size(); i++) begin
      nvec++;
      if (tq[i].d !== ed[i] || tq[i].op !== eo[i]) begin
        $display("FAIL abort_tok%0d: got (%h,%b) want (%h,%b)", i, tq[i].d, tq[i].op, ed[i], eo[i]); nerr++;
      end
    end
  endtask

  task automatic test_sep_minus();
    logic [31:0] ed [2] = '{32'h2D, 32'h0A};
    logic        eo [2] = '{1'b1, 1'b1};
    bit ok;
    tq.delete(); out_ack = 1'b1;
    send_str("  -  \n");
    wait_tokens(2, ok);
    repeat (6) @(posedge CLK); #1;
    nvec++; if (!ok || tq.size() !== 2) begin $display("FAIL sep_count: got %0d tokens want 2", tq.size()); nerr++; end
    for (int i = 0; i < 2 && i < tq.size(); i++) begin
      nvec++;
      if (tq[i].d !== ed[i] || tq[i].op !== eo[i]) begin
        $display("FAIL sep_tok%0d: got (%h,%b) want (%h,%b)", i, tq[i].d, tq[i].op, ed[i], eo[i]); nerr++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bad_char();
    test_overflow();
    test_rst_abort();
    test_sep_minus();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
